// File: rtl/instruction_fetcher_if.sv
// Handshake bundle between the instruction fetcher and its neighbours:
// icache request/response, decoder delivery and ROB redirect/branch commit.
interface instruction_fetcher_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    // Icache request / response
    logic                  IFIC_en;
    logic [ADDR_WIDTH-1:0] IFIC_addr;
    logic                  ICIF_en;
    logic [31:0]           ICIF_data;

    // Decoder delivery
    logic                  DCIF_ask_IF;
    logic                  IFDC_en;
    logic [ADDR_WIDTH-1:0] IFDC_pc;
    logic [6:0]            IFDC_opcode;
    logic [24:0]           IFDC_remain_inst;
    logic                  IFDC_predict_result;

    // ROB redirect and branch resolution
    logic                  ROBIF_jump_en;
    logic [ADDR_WIDTH-1:0] ROBIF_jump_addr;
    logic                  ROBIF_br_commit;
    logic [ADDR_WIDTH-1:0] ROBIF_br_pc;
    logic                  ROBIF_br_taken;

    // Fetcher side
    modport master (
        output IFIC_en, IFIC_addr,
        input  ICIF_en, ICIF_data,
        input  DCIF_ask_IF,
        output IFDC_en, IFDC_pc, IFDC_opcode, IFDC_remain_inst, IFDC_predict_result,
        input  ROBIF_jump_en, ROBIF_jump_addr, ROBIF_br_commit, ROBIF_br_pc, ROBIF_br_taken
    );

    // Icache / decoder / ROB side
    modport slave (
        input  IFIC_en, IFIC_addr,
        output ICIF_en, ICIF_data,
        output DCIF_ask_IF,
        input  IFDC_en, IFDC_pc, IFDC_opcode, IFDC_remain_inst, IFDC_predict_result,
        output ROBIF_jump_en, ROBIF_jump_addr, ROBIF_br_commit, ROBIF_br_pc, ROBIF_br_taken
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: requests words from the icache at the current PC, hands
// them to the decoder when asked, and predicts the next PC with a bimodal BHT.
module instruction_fetcher #(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          BHT_BITS   = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    instruction_fetcher_if.master bus
);
    localparam int unsigned BhtEntries = 1 << BHT_BITS;
    localparam logic [6:0]  OpJal      = 7'b1101111;
    localparam logic [6:0]  OpBranch   = 7'b1100011;

    typedef enum logic [1:0] {StIdle, StReq, StHold, StDrain} state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   w_pc_next;
    logic [31:0]             r_buf;
    logic [1:0]              r_bht [BhtEntries];

    logic                    r_dc_en;
    logic [ADDR_WIDTH-1:0]   r_dc_pc;
    logic [31:0]             r_dc_word;
    logic                    r_dc_pred;

    logic                    w_issue;
    logic                    w_buffer;
    logic [31:0]             w_word;
    logic [BHT_BITS-1:0]     w_rd_idx;
    logic [BHT_BITS-1:0]     w_wr_idx;
    logic [1:0]              w_ctr;
    logic [ADDR_WIDTH-1:0]   w_imm_j;
    logic [ADDR_WIDTH-1:0]   w_imm_b;
    logic [ADDR_WIDTH-1:0]   w_pred_pc;
    logic                    w_pred_taken;

    // The word being considered for issue comes from the buffer only in HOLD
    assign w_word   = (r_state == StHold) ? r_buf : bus.ICIF_data;
    assign w_rd_idx = r_pc[BHT_BITS+1:2];
    assign w_wr_idx = bus.ROBIF_br_pc[BHT_BITS+1:2];
    assign w_ctr    = r_bht[w_rd_idx];

    assign w_imm_j = {{(ADDR_WIDTH-21){w_word[31]}}, w_word[31], w_word[19:12], w_word[20],
                      w_word[30:21], 1'b0};
    assign w_imm_b = {{(ADDR_WIDTH-13){w_word[31]}}, w_word[31], w_word[7], w_word[30:25],
                      w_word[11:8], 1'b0};

    // Next-PC prediction from the opcode of the candidate word
    always_comb begin
        w_pred_pc    = r_pc + ADDR_WIDTH'(4);
        w_pred_taken = 1'b0;
        if (w_word[6:0] == OpJal) begin
            w_pred_pc    = r_pc + w_imm_j;
            w_pred_taken = 1'b1;
        end else if (w_word[6:0] == OpBranch && w_ctr[1]) begin
            w_pred_pc    = r_pc + w_imm_b;
            w_pred_taken = 1'b1;
        end
    end

    // FSM next state, issue/buffer decisions and next PC; redirect wins over everything
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_issue      = 1'b0;
        w_buffer     = 1'b0;
        if (bus.ROBIF_jump_en) begin
            w_pc_next = bus.ROBIF_jump_addr;
            unique case (r_state)
                StReq:   w_state_next = bus.ICIF_en ? StReq : StDrain;
                // A response landing with the redirect has already been drained;
                // waiting for another one would never end since none is requested.
                StDrain: w_state_next = bus.ICIF_en ? StReq : StDrain;
                default: w_state_next = StReq;
            endcase
        end else begin
            unique case (r_state)
                StIdle: w_state_next = StReq;
                StReq: begin
                    if (bus.ICIF_en) begin
                        if (bus.DCIF_ask_IF) begin
                            w_issue = 1'b1;
                        end else begin
                            w_buffer     = 1'b1;
                            w_state_next = StHold;
                        end
                    end
                end
                StHold: begin
                    if (bus.DCIF_ask_IF) begin
                        w_issue      = 1'b1;
                        w_state_next = StReq;
                    end
                end
                StDrain: if (bus.ICIF_en) w_state_next = StReq;
                default: w_state_next = StIdle;
            endcase
            if (w_issue) w_pc_next = w_pred_pc;
        end
    end

    // State, PC, buffer and decoder output registers; frozen while not ready
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= StIdle;
            r_pc      <= RESET_PC;
            r_buf     <= '0;
            r_dc_en   <= 1'b0;
            r_dc_pc   <= '0;
            r_dc_word <= '0;
            r_dc_pred <= 1'b0;
        end else if (rdy_in) begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_dc_en <= w_issue;
            if (w_buffer) r_buf <= bus.ICIF_data;
            if (w_issue) begin
                r_dc_pc   <= r_pc;
                r_dc_word <= w_word;
                r_dc_pred <= w_pred_taken;
            end
        end
    end

    // BHT: 2-bit saturating counters trained by committed branches
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BhtEntries; i++) r_bht[i] <= 2'b01;
        end else if (rdy_in && bus.ROBIF_br_commit) begin
            if (bus.ROBIF_br_taken) begin
                if (r_bht[w_wr_idx] != 2'b11) r_bht[w_wr_idx] <= r_bht[w_wr_idx] + 2'b01;
            end else begin
                if (r_bht[w_wr_idx] != 2'b00) r_bht[w_wr_idx] <= r_bht[w_wr_idx] - 2'b01;
            end
        end
    end

    assign bus.IFIC_en             = (r_state == StReq);
    assign bus.IFIC_addr           = r_pc;
    // A pulse caught by a stall is held and delivered once ready returns
    assign bus.IFDC_en             = r_dc_en & rdy_in;
    assign bus.IFDC_pc             = r_dc_pc;
    assign bus.IFDC_opcode         = r_dc_word[6:0];
    assign bus.IFDC_remain_inst    = r_dc_word[31:7];
    assign bus.IFDC_predict_result = r_dc_pred;

    // Only the index bits of the committed branch PC matter
    logic w_unused_br_pc;
    assign w_unused_br_pc = ^{bus.ROBIF_br_pc[ADDR_WIDTH-1:BHT_BITS+2], bus.ROBIF_br_pc[1:0]};
endmodule
